user_logic_top: RTL and testbench

USER_LOGIC_TOP -- requirements
Module: user_logic_top

---
 rtl/user_logic_top.sv | 205 ++++++++++++++++++++
 tb/tb_user_logic_top.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_logic_top.sv
// 3x3 binomial smoothing of one 512-pixel image line: streams 1-3 load the
// top/middle/bottom lines, a control write starts filtering, results return on stream 1.
module user_logic_top #(
  parameter int          LINE_WORDS = 64,
  parameter logic [19:0] CTRL_ADDR  = 20'h0
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic [31:0] i_user_data,
  input  logic [19:0] i_user_addr,
  input  logic        i_user_wr_req,
  input  logic        i_user_rd_req,
  output logic [31:0] o_user_data,
  output logic        o_user_rd_ack,
  input  logic        i_pcie_str1_data_valid,
  input  logic [63:0] i_pcie_str1_data,
  output logic        o_pcie_str1_ack,
  input  logic        i_pcie_str2_data_valid,
  input  logic [63:0] i_pcie_str2_data,
  output logic        o_pcie_str2_ack,
  input  logic        i_pcie_str3_data_valid,
  input  logic [63:0] i_pcie_str3_data,
  output logic        o_pcie_str3_ack,
  input  logic        i_pcie_str4_data_valid,
  input  logic [63:0] i_pcie_str4_data,
  output logic        o_pcie_str4_ack,
  output logic        o_pcie_str1_data_valid,
  output logic [63:0] o_pcie_str1_data,
  input  logic        i_pcie_str1_ack,
  output logic        o_pcie_str2_data_valid,
  output logic [63:0] o_pcie_str2_data,
  input  logic        i_pcie_str2_ack,
  output logic        o_pcie_str3_data_valid,
  output logic [63:0] o_pcie_str3_data,
  input  logic        i_pcie_str3_ack,
  output logic        o_pcie_str4_data_valid,
  output logic [63:0] o_pcie_str4_data,
  input  logic        i_pcie_str4_ack,
  output logic        o_intr_req,
  input  logic        i_intr_ack
);
  localparam int PW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CW = $clog2(LINE_WORDS + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(LINE_WORDS);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state_q, state_d;
  logic          in_ack_q, in_ack_d;
  logic [PW-1:0] ptr1_q, ptr1_d, ptr2_q, ptr2_d, ptr3_q, ptr3_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          intr_q, intr_d;
  logic          rd_ack_q, rd_ack_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic [63:0] top_mem [LINE_WORDS];
  logic [63:0] mid_mem [LINE_WORDS];
  logic [63:0] bot_mem [LINE_WORDS];

  logic          start, wr1, wr2, wr3, xfer;
  logic [PW-1:0] k, k_prv, k_nxt;
  logic [79:0]   t_win, m_win, b_win;
  logic [63:0]   filt;
  logic          unused_inputs;

  // Pixel window for one word: byte 0 = left neighbour, bytes 1..8 = word, byte 9 = right
  // neighbour; the outermost pixels of the line replicate into the missing neighbour.
  function automatic logic [79:0] window(input logic [63:0] cur, input logic [63:0] prv,
                                         input logic [63:0] nxt, input logic first,
                                         input logic last);
    window = {last ? cur[63:56] : nxt[7:0], cur, first ? cur[7:0] : prv[63:56]};
  endfunction

  function automatic logic [63:0] smooth(input logic [79:0] t, input logic [79:0] m,
                                         input logic [79:0] b);
    logic [11:0] s;
    smooth = '0;
    for (int i = 0; i < 8; i++) begin
      s = {4'b0, t[8*i +: 8]} + {3'b0, t[8*i+8 +: 8], 1'b0} + {4'b0, t[8*i+16 +: 8]}
        + {3'b0, m[8*i +: 8], 1'b0} + {2'b0, m[8*i+8 +: 8], 2'b0} + {3'b0, m[8*i+16 +: 8], 1'b0}
        + {4'b0, b[8*i +: 8]} + {3'b0, b[8*i+8 +: 8], 1'b0} + {4'b0, b[8*i+16 +: 8]} + 12'd8;
      smooth[8*i +: 8] = s[11:4];
    end
  endfunction

  assign start = i_user_wr_req && (i_user_addr == CTRL_ADDR) && i_user_data[0]
                 && (state_q == S_IDLE);
  assign wr1   = in_ack_q && i_pcie_str1_data_valid;
  assign wr2   = in_ack_q && i_pcie_str2_data_valid;
  assign wr3   = in_ack_q && i_pcie_str3_data_valid;
  assign xfer  = out_valid_q && i_pcie_str1_ack;
  assign k     = idx_q[PW-1:0];
  assign k_prv = k - 1'b1;
  assign k_nxt = k + 1'b1;

  always_comb begin
    t_win = window(top_mem[k], top_mem[k_prv], top_mem[k_nxt], k == '0, k == PTR_LAST);
    m_win = window(mid_mem[k], mid_mem[k_prv], mid_mem[k_nxt], k == '0, k == PTR_LAST);
    b_win = window(bot_mem[k], bot_mem[k_prv], bot_mem[k_nxt], k == '0, k == PTR_LAST);
    filt  = smooth(t_win, m_win, b_win);
  end

  always_ff @(posedge i_user_clk) begin
    if (wr1) top_mem[ptr1_q] <= i_pcie_str1_data;
    if (wr2) mid_mem[ptr2_q] <= i_pcie_str2_data;
    if (wr3) bot_mem[ptr3_q] <= i_pcie_str3_data;
  end

  always_comb begin
    state_d     = state_q;
    ptr1_d      = ptr1_q;
    ptr2_d      = ptr2_q;
    ptr3_d      = ptr3_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    intr_d      = intr_q;
    if (wr1) ptr1_d = (ptr1_q == PTR_LAST) ? '0 : ptr1_q + 1'b1;
    if (wr2) ptr2_d = (ptr2_q == PTR_LAST) ? '0 : ptr2_q + 1'b1;
    if (wr3) ptr3_d = (ptr3_q == PTR_LAST) ? '0 : ptr3_q + 1'b1;
    if (i_intr_ack) intr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          idx_d   = '0;
        end
      end
      S_BUSY: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
        // Output register refills whenever it is empty or being drained this cycle.
        if ((!out_valid_q || i_pcie_str1_ack) && (idx_q != CNT_END)) begin
          out_valid_d = 1'b1;
          out_data_d  = filt;
          idx_d       = idx_q + 1'b1;
        end
        if (xfer && (idx_q == CNT_END)) begin
          state_d = S_IDLE;
          ptr1_d  = '0;
          ptr2_d  = '0;
          ptr3_d  = '0;
          intr_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ack_d  = (state_d == S_IDLE);
    rd_ack_d  = i_user_rd_req;
    rd_data_d = (i_user_rd_req && (i_user_addr == CTRL_ADDR))
                ? {30'b0, state_q == S_BUSY, intr_q} : '0;
  end

  always_ff @(posedge i_user_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      in_ack_q    <= 1'b0;
      ptr1_q      <= '0;
      ptr2_q      <= '0;
      ptr3_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      intr_q      <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ack_q    <= in_ack_d;
      ptr1_q      <= ptr1_d;
      ptr2_q      <= ptr2_d;
      ptr3_q      <= ptr3_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      intr_q      <= intr_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign o_pcie_str1_ack        = in_ack_q;
  assign o_pcie_str2_ack        = in_ack_q;
  assign o_pcie_str3_ack        = in_ack_q;
  assign o_pcie_str4_ack        = 1'b0;
  assign o_pcie_str1_data_valid = out_valid_q;
  assign o_pcie_str1_data       = out_data_q;
  assign o_pcie_str2_data_valid = 1'b0;
  assign o_pcie_str2_data       = '0;
  assign o_pcie_str3_data_valid = 1'b0;
  assign o_pcie_str3_data       = '0;
  assign o_pcie_str4_data_valid = 1'b0;
  assign o_pcie_str4_data       = '0;
  assign o_intr_req             = intr_q;
  assign o_user_rd_ack          = rd_ack_q;
  assign o_user_data            = rd_data_q;

  assign unused_inputs = ^{i_user_data[31:1], i_pcie_str4_data_valid, i_pcie_str4_data,
                           i_pcie_str2_ack, i_pcie_str3_ack, i_pcie_str4_ack};
endmodule

// File: tb/tb_user_logic_top.sv
// Bench for user_logic_top: loads lines, starts the filter, and checks every output word
// against a pixel-level smoothing model; also covers status reads, stalls and reset abort.
module tb_user_logic_top;
  localparam int LW   = 64;
  localparam int NPIX = LW * 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] user_data = '0;
  logic [19:0] user_addr = '0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [31:0] o_user_data;
  logic        o_user_rd_ack;
  logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0, v4 = 1'b0;
  logic [63:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic        o_ack1, o_ack2, o_ack3, o_ack4;
  logic        ov1, ov2, ov3, ov4;
  logic [63:0] od1, od2, od3, od4;
  logic        h_ack1 = 1'b0, h_ack2 = 1'b1, h_ack3 = 1'b1, h_ack4 = 1'b1;
  logic        o_intr_req;
  logic        intr_ack = 1'b0;

  user_logic_top #(.LINE_WORDS(LW), .CTRL_ADDR(20'h0)) dut (
    .i_user_clk(clk), .i_rst(rst_n),
    .i_user_data(user_data), .i_user_addr(user_addr),
    .i_user_wr_req(wr_req), .i_user_rd_req(rd_req),
    .o_user_data(o_user_data), .o_user_rd_ack(o_user_rd_ack),
    .i_pcie_str1_data_valid(v1), .i_pcie_str1_data(d1), .o_pcie_str1_ack(o_ack1),
    .i_pcie_str2_data_valid(v2), .i_pcie_str2_data(d2), .o_pcie_str2_ack(o_ack2),
    .i_pcie_str3_data_valid(v3), .i_pcie_str3_data(d3), .o_pcie_str3_ack(o_ack3),
    .i_pcie_str4_data_valid(v4), .i_pcie_str4_data(d4), .o_pcie_str4_ack(o_ack4),
    .o_pcie_str1_data_valid(ov1), .o_pcie_str1_data(od1), .i_pcie_str1_ack(h_ack1),
    .o_pcie_str2_data_valid(ov2), .o_pcie_str2_data(od2), .i_pcie_str2_ack(h_ack2),
    .o_pcie_str3_data_valid(ov3), .o_pcie_str3_data(od3), .i_pcie_str3_ack(h_ack3),
    .o_pcie_str4_data_valid(ov4), .o_pcie_str4_data(od4), .i_pcie_str4_ack(h_ack4),
    .o_intr_req(o_intr_req), .i_intr_ack(intr_ack)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [63:0] t_w [LW];
  logic [63:0] m_w [LW];
  logic [63:0] b_w [LW];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: unpack lines to pixel arrays, apply the 3x3 kernel with clamped columns.
  task automatic build_exp();
    int t[NPIX];
    int m[NPIX];
    int b[NPIX];
    exp_q.delete();
    got_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      t[p] = int'(t_w[p / 8][8 * (p % 8) +: 8]);
      m[p] = int'(m_w[p / 8][8 * (p % 8) +: 8]);
      b[p] = int'(b_w[p / 8][8 * (p % 8) +: 8]);
    end
    for (int w = 0; w < LW; w++) begin
      logic [63:0] word = '0;
      for (int j = 0; j < 8; j++) begin
        int p = 8 * w + j;
        int l = (p == 0) ? 0 : p - 1;
        int r = (p == NPIX - 1) ? p : p + 1;
        int s = t[l] + 2 * t[p] + t[r] + 2 * m[l] + 4 * m[p] + 2 * m[r]
              + b[l] + 2 * b[p] + b[r] + 8;
        word[8 * j +: 8] = 8'(s / 16);
      end
      exp_q.push_back(word);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < LW; i++) begin
      t_w[i] = {$urandom, $urandom};
      m_w[i] = {$urandom, $urandom};
      b_w[i] = {$urandom, $urandom};
    end
  endtask

  task automatic fill_const(input logic [63:0] val);
    for (int i = 0; i < LW; i++) begin
      t_w[i] = val;
      m_w[i] = val;
      b_w[i] = val;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_lines();
    @(negedge clk);
    check("idle_in_acks", {61'b0, o_ack3, o_ack2, o_ack1}, 64'h7);
    for (int i = 0; i < LW; i++) begin
      @(posedge clk); #1;
      v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
      d1 = t_w[i]; d2 = m_w[i]; d3 = b_w[i];
    end
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

  task automatic reg_write(input logic [19:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wr_req = 1'b1; user_addr = addr; user_data = data;
    @(posedge clk); #1;
    wr_req = 1'b0; user_data = '0;
  endtask

  task automatic reg_read(input logic [19:0] addr, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    rd_req = 1'b1; user_addr = addr;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack"}, {63'b0, o_user_rd_ack}, 64'h1);
    check({tag, "_data"}, {32'b0, o_user_data}, {32'b0, exp});
    @(negedge clk);
    check({tag, "_ack_pulse"}, {63'b0, o_user_rd_ack}, 64'h0);
  endtask

  task automatic wait_first_valid();
    for (int c = 0; c < 8 && !ov1; c++) @(negedge clk);
    check("first_valid_latency", {63'b0, ov1}, 64'h1);
  endtask

  // Pulls n words off stream 1; every valid cycle, stalled or not, must show the next model word.
  task automatic collect(input int n, input bit rand_ack);
    int got = 0;
    int cyc = 0;
    @(posedge clk); #1;
    h_ack1 = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      if (ov1) begin
        if (got_q.size() < LW)
          check($sformatf("word%0d", got_q.size()), od1, exp_q[got_q.size()]);
        else
          check("extra_word_valid", {63'b0, ov1}, 64'h0);
        if (h_ack1) begin
          got_q.push_back(od1);
          got++;
        end
      end
      @(posedge clk); #1;
      h_ack1 = (got < n) ? (rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
      cyc++;
    end
    h_ack1 = 1'b0;
    check("words_collected", 64'(got), 64'(n));
  endtask

  task automatic expect_quiet(input int cycles, input string tag);
    h_ack1 = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check(tag, {63'b0, ov1}, 64'h0);
    end
    h_ack1 = 1'b0;
  endtask

  task automatic finish_frame();
    check("frame_word_total", 64'(got_q.size()), 64'(LW));
    expect_quiet(4, "no_word_after_last");
    check("intr_set", {63'b0, o_intr_req}, 64'h1);
    reg_read(20'h0, 32'h1, "status_done");
    @(posedge clk); #1 intr_ack = 1'b1;
    @(posedge clk); #1 intr_ack = 1'b0;
    @(negedge clk);
    check("intr_cleared", {63'b0, o_intr_req}, 64'h0);
    reg_read(20'h0, 32'h0, "status_idle");
  endtask

  task automatic run_frame(input bit rand_ack);
    build_exp();
    load_lines();
    reg_write(20'h0, 32'h1);
    wait_first_valid();
    collect(LW, rand_ack);
    finish_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_acks"}, {60'b0, o_ack4, o_ack3, o_ack2, o_ack1}, 64'h0);
    check({tag, "_out_valids"}, {60'b0, ov4, ov3, ov2, ov1}, 64'h0);
    check({tag, "_out_data"}, od1 | od2 | od3 | od4, 64'h0);
    check({tag, "_rd_ack_intr"}, {62'b0, o_user_rd_ack, o_intr_req}, 64'h0);
    check({tag, "_user_data"}, {32'b0, o_user_data}, 64'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Uniform grey field passes through unchanged.
    fill_const(64'h8080808080808080);
    run_frame(1'b0);
    check("grey_word0", got_q[0], 64'h8080808080808080);

    // Single bright middle pixel at index 10 (word 1, byte 2).
    fill_const(64'h0);
    m_w[1] = 64'h0000000000FF0000;
    run_frame(1'b0);
    check("mid_px10_word1", got_q[1], 64'h0000000020402000);
    check("mid_px10_word0", got_q[0], 64'h0);

    // Top-left pixel: left edge replication.
    fill_const(64'h0);
    t_w[0] = 64'h00000000000000FF;
    run_frame(1'b1);
    check("top_px0_word0", got_q[0], 64'h0000000000001030);

    // Random image, 5-cycle stall mid-transfer with a status read and a rejected second start.
    fill_random();
    build_exp();
    load_lines();
    reg_write(20'h0, 32'h1);
    wait_first_valid();
    collect(20, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", {63'b0, ov1}, 64'h1);
      check("stall_data", od1, exp_q[20]);
    end
    check("busy_in_acks", {61'b0, o_ack3, o_ack2, o_ack1}, 64'h0);
    check("busy_other_streams", {61'b0, ov4, ov3, ov2} | {63'b0, o_ack4}, 64'h0);
    reg_read(20'h0, 32'h2, "status_busy");
    reg_write(20'h0, 32'h1);
    collect(LW - 20, 1'b1);
    finish_frame();

    // Random image with random backpressure throughout.
    fill_random();
    run_frame(1'b1);

    // Reset mid-transfer aborts the frame.
    fill_random();
    build_exp();
    load_lines();
    reg_write(20'h0, 32'h1);
    wait_first_valid();
    collect(10, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_reset_in_acks", {61'b0, o_ack3, o_ack2, o_ack1}, 64'h7);
    expect_quiet(20, "no_word_after_reset");
    reg_read(20'h0, 32'h0, "status_after_reset");

    // Writes with bit0=0 or to another address do not start.
    reg_write(20'h0, 32'h2);
    reg_write(20'h4, 32'h1);
    expect_quiet(10, "ignored_start");
    reg_read(20'h0, 32'h0, "status_ignored");
    reg_read(20'h8, 32'h0, "other_addr_read");

    // Fresh frame after the abort.
    fill_random();
    run_frame(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
